// File: rtl/ln_series_sequencer.sv
// ln(x) via a shared-core Taylor series, ln(1+y) with y = x - 1.
// Define LN_RANGE_CHECK_EN to reject inputs outside (0, 2.0] with err.
package ln_fp_pkg;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] ONE = 32'h3F800000;

  // Round-to-nearest-even and pack; denormal results flush to zero.
  function automatic logic [31:0] round_pack(
    input logic sgn,
    input logic signed [10:0] e,
    input logic [23:0] m,
    input logic g,
    input logic st
  );
    logic up;
    logic [24:0] mr;
    logic signed [10:0] e2;
    logic [22:0] f;
    up = g & (st | m[0]);
    mr = {1'b0, m} + 25'(up);
    e2 = e;
    f = mr[22:0];
    if (mr[24]) begin
      e2 = e + 11'sd1;
      f = mr[23:1];
    end
    if (e2 >= 11'sd255) round_pack = {sgn, 8'hFF, 23'd0};
    else if (e2 <= 11'sd0) round_pack = {sgn, 31'd0};
    else round_pack = {sgn, e2[7:0], f};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction
endpackage

module spfp_adder_subtractor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] res
);
  import ln_fp_pkg::*;
  logic sa, sb, za, zb, swap, sg;
  logic [30:0] ka, kb;
  logic [7:0] eb, es, d;
  logic [23:0] mb, ms;
  logic [4:0] dsh, lz;
  logic [53:0] tmp;
  logic [26:0] mb3, ms3, n;
  logic [27:0] s;
  logic signed [10:0] e;
  logic na, nb;

  always_comb begin
    sa = a[31];
    sb = b[31] ^ ~op;
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ka = za ? 31'd0 : a[30:0];
    kb = zb ? 31'd0 : b[30:0];
    swap = kb > ka;
    sg = swap ? sb : sa;
    eb = swap ? kb[30:23] : ka[30:23];
    es = swap ? ka[30:23] : kb[30:23];
    mb = swap ? {~zb, kb[22:0]} : {~za, ka[22:0]};
    ms = swap ? {~za, ka[22:0]} : {~zb, kb[22:0]};
    d = eb - es;
    dsh = (d > 8'd27) ? 5'd27 : d[4:0];
    tmp = {ms, 3'b000, 27'd0} >> dsh;
    ms3 = {tmp[53:28], tmp[27] | (|tmp[26:0])};
    mb3 = {mb, 3'b000};
    if (sa == sb) s = {1'b0, mb3} + {1'b0, ms3};
    else s = {1'b0, mb3} - {1'b0, ms3};
    lz = lzc27(s[26:0]);
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = $signed({3'b000, eb}) + 11'sd1;
    end else begin
      n = s[26:0] << lz;
      e = $signed({3'b000, eb}) - $signed({6'd0, lz});
    end
    if (s == 28'd0) res = 32'd0;
    else res = round_pack(sg, e, n[26:3], n[2], |n[1:0]);
    na = &a[30:23];
    nb = &b[30:23];
    if ((na && a[22:0] != 0) || (nb && b[22:0] != 0) ||
        (na && nb && sa != sb)) res = QNAN;
    else if (na) res = {sa, 8'hFF, 23'd0};
    else if (nb) res = {sb, 8'hFF, 23'd0};
  end
endmodule

module spfp_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  import ln_fp_pkg::*;
  logic s, za, zb, na, nb;
  logic [47:0] p;
  logic signed [10:0] e;

  always_comb begin
    s = a[31] ^ b[31];
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    na = &a[30:23];
    nb = &b[30:23];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) res = round_pack(s, e + 11'sd1, p[47:24], p[23], |p[22:0]);
    else res = round_pack(s, e, p[46:23], p[22], |p[21:0]);
    if ((na && a[22:0] != 0) || (nb && b[22:0] != 0) ||
        (na && zb) || (nb && za)) res = QNAN;
    else if (na || nb) res = {s, 8'hFF, 23'd0};
    else if (za || zb) res = {s, 31'd0};
  end
endmodule

module spfp_divider (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  import ln_fp_pkg::*;
  logic s, za, zb, na, nb, rnz;
  logic [49:0] num, den;
  logic [26:0] q;
  logic signed [10:0] e;

  always_comb begin
    s = a[31] ^ b[31];
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    na = &a[30:23];
    nb = &b[30:23];
    num = {1'b1, a[22:0], 26'd0};
    den = zb ? 50'd1 : {26'd0, 1'b1, b[22:0]};
    q = 27'(num / den);
    rnz = (num % den) != 50'd0;
    e = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127;
    if (q[26]) res = round_pack(s, e, q[26:3], q[2], (|q[1:0]) | rnz);
    else res = round_pack(s, e - 11'sd1, q[25:2], q[1], q[0] | rnz);
    if ((na && a[22:0] != 0) || (nb && b[22:0] != 0) ||
        (na && nb) || (za && zb)) res = QNAN;
    else if (na || zb) res = {s, 8'hFF, 23'd0};
    else if (za || nb) res = {s, 31'd0};
  end
endmodule

module ln_series_sequencer #(
  parameter int NUM_TERMS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        err
);
  import ln_fp_pkg::*;

  typedef enum logic [2:0] {IDLE, SUB, POW, DIV, ACC, FIN} state_t;
  localparam logic [3:0] LAST = 4'(NUM_TERMS);

  state_t state, state_nxt;
  logic [31:0] x_reg, y, pow, term, acc;
  logic [31:0] add_a, add_b, add_res, mul_res, div_res, div_k;
  logic [3:0] k;
  logic add_op, bad, bad_q;

`ifdef LN_RANGE_CHECK_EN
  logic err_q;
  assign bad = x_in[31] | (&x_in[30:23]) |
               (x_in[30:0] == 31'd0) | (x_in > 32'h40000000);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      bad_q <= bad;
      err_q <= 1'b0;
    end else if (state == FIN) begin
      err_q <= bad_q;
    end
  end
  assign err = err_q;
`else
  assign bad = 1'b0;
  assign bad_q = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    unique case (k)
      4'd3: div_k = 32'h40400000;
      4'd4: div_k = 32'h40800000;
      4'd5: div_k = 32'h40A00000;
      4'd6: div_k = 32'h40C00000;
      4'd7: div_k = 32'h40E00000;
      4'd8: div_k = 32'h41000000;
      default: div_k = 32'h40000000;
    endcase
  end

  // Odd k adds the term, even k subtracts it.
  assign add_a = (state == SUB) ? x_reg : acc;
  assign add_b = (state == SUB) ? ONE : term;
  assign add_op = (state == SUB) ? 1'b0 : k[0];

  spfp_adder_subtractor u_add (.a(add_a), .b(add_b), .op(add_op), .res(add_res));
  spfp_multiplier u_mul (.a(pow), .b(y), .res(mul_res));
  spfp_divider u_div (.a(pow), .b(div_k), .res(div_res));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = bad ? FIN : SUB;
      SUB: state_nxt = (LAST == 4'd1) ? FIN : POW;
      POW: state_nxt = DIV;
      DIV: state_nxt = ACC;
      ACC: state_nxt = (k == LAST) ? FIN : POW;
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y <= '0;
      pow <= '0;
      term <= '0;
      acc <= '0;
      k <= '0;
      out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_reg <= x_in;
            busy <= 1'b1;
          end
        end
        SUB: begin
          y <= add_res;
          pow <= add_res;
          acc <= add_res;
          k <= 4'd2;
        end
        POW: pow <= mul_res;
        DIV: term <= div_res;
        ACC: begin
          acc <= add_res;
          if (k != LAST) k <= k + 4'd1;
        end
        FIN: begin
          out <= bad_q ? QNAN : acc;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ln_series_sequencer.sv
// Directed bench for ln_series_sequencer (NUM_TERMS=5 and NUM_TERMS=1).
module tb_ln_series_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] x1 = '0;
  logic busy, done, err, busy1, done1, err1;
  logic [31:0] out, out1;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ln_series_sequencer #(.NUM_TERMS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .out(out), .err(err)
  );

  ln_series_sequencer #(.NUM_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x_in(x1),
    .busy(busy1), .done(done1), .out(out1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    logic [31:0] d;
    logic ok;
    d = (obs > exp) ? obs - exp : exp - obs;
    ok = (obs[31] == exp[31]) && (d <= 32'd1);
    nchk++;
    assert (ok === 1'b1) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h+-1ulp", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input logic [31:0] x, output int lat, output logic b);
    x_in = x;
    start = 1'b1;
    step();
    b = busy;
    start = 1'b0;
    x_in = 32'hDEADBEEF;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic b;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    run(32'h3F800000, lat, b);
    check("one_busy", 32'(b), 32'd1);
    check("one_lat", 32'(lat), 32'd14);
    check("one_out", out, 32'h00000000);
    check("one_err", 32'(err), 32'd0);
    check("one_busy_end", 32'(busy), 32'd0);
    step();
    check("one_done_pulse", 32'(done), 32'd0);

    run(32'h3FC00000, lat, b);
    check("p15_lat", 32'(lat), 32'd14);
    check_ulp("p15_out", out, 32'h3ED08888);
    step();

    run(32'h3F000000, lat, b);
    check("p05_lat", 32'(lat), 32'd14);
    check_ulp("p05_out", out, 32'hBF304445);
    step();

    x_in = 32'h3FC00000;
    start = 1'b1;
    step();
    x_in = 32'h3F000000;
    wait_done(lat);
    check("hold_lat", 32'(lat), 32'd14);
    check_ulp("hold_out", out, 32'h3ED08888);
    step();
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'd14);
    check_ulp("b2b_out", out, 32'hBF304445);
    step();

    x_in = 32'h3FC00000;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("ab_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_out", out, 32'd0);
    step();
    rst = 1'b0;
    step();
    run(32'h3FC00000, lat, b);
    check("ab_rerun_lat", 32'(lat), 32'd14);
    check_ulp("ab_rerun_out", out, 32'h3ED08888);
    step();

    x1 = 32'h3FC00000;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done1) begin
        lat = i;
        break;
      end
    end
    check("n1_lat", 32'(lat), 32'd2);
    check("n1_out", out1, 32'h3F000000);
    step();

`ifdef LN_RANGE_CHECK_EN
    run(32'hBF800000, lat, b);
    check("rc_lat", 32'(lat), 32'd1);
    check("rc_out", out, 32'h7FC00000);
    check("rc_err", 32'(err), 32'd1);
    step();
    check("rc_err_hold", 32'(err), 32'd1);
    run(32'h3F800000, lat, b);
    check("rc_ok_lat", 32'(lat), 32'd14);
    check("rc_ok_err", 32'(err), 32'd0);
    check("rc_ok_out", out, 32'd0);
`else
    run(32'hBF800000, lat, b);
    check("neg_lat", 32'(lat), 32'd14);
    check("neg_err", 32'(err), 32'd0);
`endif
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ln_series_sequencer.md
Name: ln_series_sequencer

Overview:
- Multi-cycle, resource-shared evaluator of ln(x) using the 5-term (default) Taylor series ln(1+y) = y - y^2/2 + y^3/3 - ..., where y = x - 1.
- Instantiates exactly one spfp_multiplier, one division and one spfp_adder_subtractor, all combinational.
- An FSM time-multiplexes these cores across the terms instead of building one unit per term.
- Sits between the neuron activation/loss logic and the floating-point cores, with a start/done handshake.

Parameters:
- NUM_TERMS, 5, number of series terms; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x_in  input  32  IEEE-754 single operand; latched on the accepting edge.
- busy  output  1  high while an evaluation is in progress.
- done  output  1  one-cycle pulse when out is valid.
- out  output  32  IEEE-754 single result; holds until the next done.
- err  output  1  domain error flag (see Optional Feature); tied 0 when the feature is off.

Behaviour:
- Reset: clk and rst as above (one clock; reset asynchronous, active-high).
  - rst forces state=IDLE and clears busy, done, out, err, and all internal regs (x_reg, y, pow, term, acc, k) to 0.
  - Applies immediately, including mid-operation; the aborted result is discarded.
- Adder/subtractor op select follows the core convention: 0 = subtract, 1 = add.
- Divisor constant table, indexed by k:
  - 2 = 0x40000000, 3 = 0x40400000, 4 = 0x40800000, 5 = 0x40A00000
  - 6 = 0x40C00000, 7 = 0x40E00000, 8 = 0x41000000
- FSM states, one clock each:
  - IDLE: done<=0. If start, then x_reg<=x_in, busy<=1, go SUB. Otherwise hold.
  - SUB: y<=x_reg-1.0 (0x3F800000, op=0); pow<=x_reg-1.0; acc<=x_reg-1.0; k<=2.
    - If NUM_TERMS==1, go FIN. Otherwise go POW.
  - POW: pow<=pow*y; go DIV.
  - DIV: term<=pow/const[k]; go ACC.
  - ACC: acc<=acc-term if k even, acc+term if k odd.
    - If k==NUM_TERMS, go FIN. Otherwise k<=k+1 and go POW.
  - FIN: out<=acc, done<=1, busy<=0, go IDLE.
- Timing:
  - Outputs are registered.
  - Latency from the start-sampling edge to the edge that raises done = 3*NUM_TERMS - 1 edges (14 for the default).
  - done is high for exactly one cycle.
- Handshake and boundaries:
  - start while busy is ignored; no queuing.
  - start in the same cycle done is high: state is already IDLE, so the request is accepted and a back-to-back run begins.
  - x_in changes after acceptance have no effect.
  - out is stable from done until the next FIN.
- Arithmetic: no rounding beyond what the cores do; no guard against series divergence when |y|>=1 unless the feature is enabled.

Optional Feature:
- Macro: LN_RANGE_CHECK_EN.
- Defined: on the accepting IDLE edge, x_in is checked. It is illegal if any of the following holds:
  - sign=1
  - exponent==0xFF (Inf/NaN)
  - x_in[30:0]==0
  - x_in>0x40000000 (above 2.0, outside the convergence domain)
- Illegal input: go to FIN directly; at the next edge out<=0x7FC00000, err<=1, done<=1.
- err holds until the next accepted start, which clears it.
- Legal input: normal flow, err=0.
- Undefined: no check is performed; err is constant 0 and every input follows the normal flow.

Test Plan:
- x_in=0x3F800000 (1.0), start one cycle -> busy high, done pulse 14 edges later, out=0x00000000, err=0.
- x_in=0x3FC00000 (1.5) -> out approx 0.40729167 (0x3ED08888 ±1 ulp). x_in=0x3F000000 (0.5) -> out approx -0.68854167 ±1 ulp.
- Hold start high through a run with x_in changing mid-run -> only one done per 14 cycles.
  - Result uses the latched x_in.
  - start asserted during the done cycle is accepted: second done 14 edges later.
- Assert rst asynchronously 6 cycles into a run -> busy, done, out drop to 0 without waiting for clk. After release, a new start with 0x3FC00000 completes correctly.
- NUM_TERMS=1, x_in=0x3FC00000 -> done after 2 edges, out=0x3F000000.
- LN_RANGE_CHECK_EN defined:
  - x_in=0xBF800000 -> done after 1 edge, out=0x7FC00000, err=1.
  - Next start with 0x3F800000 -> err=0, out=0.
  - Macro undefined, x_in=0xBF800000 -> full 14-edge run, err=0.
